vlc_bit_packer: RTL and testbench
=================================

Name: vlc_bit_packer

Overview:
- Sits downstream of the DC/AC VLC stages.
- Accepts variable-length codewords (value plus length, 0..32 bits) while the sequencer has VLC output enabled.
- Packs them MSB-first into a contiguous bitstream and emits 32-bit words through a small output FIFO with a valid/ready handshake.
- A flush request, driven from the sequencer's AC flush strobe at the end of a slice, zero-pads the residual bits to a word boundary and signals completion.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit output words buffered (power of two, minimum 2)

Ports:
- clock  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  codeword present
- in_code  input  32  codeword, right-justified; only the low in_len bits are used
- in_len  input  6  codeword length in bits, 0..32; values >32 are treated as 32
- in_flush  input  1  flush request, sampled together with in_valid
- in_ready  output  1  packer can accept a codeword or flush this cycle
- out_data  output  32  packed word; first bit of the stream is bit 31
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer takes out_data
- flush_done  output  1  one-cycle pulse when a flush has completed
- total_bits  output  32  bit count of the stream (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty; accumulator and fill count 0; FSM in S_RUN.
  - Reset mid-operation discards all buffered bits and words immediately.
- State:
  - acc[63:0]: pending bits, left-aligned.
  - fill: pending bit count, 0..31 between cycles.
- FSM states: S_RUN, S_FLUSH.
- S_RUN:
  - in_ready = (FIFO count < FIFO_DEPTH).
  - Accept occurs when in_valid && in_ready.
  - On accept, the low L = min(in_len,32) bits of in_code are appended directly after the existing fill bits.
  - new = fill+L. If new >= 32, the top 32 bits are pushed into the FIFO at the same edge and the remaining new-32 bits are left-aligned in acc. Otherwise acc and fill are updated only.
  - At most one word is produced per accept, so there is no overflow while in_ready is honoured.
  - L=0 with no flush is a no-op, but the accept still counts as a handshake.
  - Accept with in_flush=1: the codeword, if L>0, is appended first in the same cycle, then the FSM moves to S_FLUSH.
  - in_flush with in_valid=0 is ignored.
- S_FLUSH:
  - in_ready = 0.
  - If fill>0 and the FIFO is not full: push {residual bits, zero padding} as one word, set fill=0, pulse flush_done, return to S_RUN.
  - If fill==0: pulse flush_done on the first S_FLUSH cycle and return to S_RUN; no word is pushed.
  - If the FIFO is full: wait in S_FLUSH.
- Latency: a word completed by an accept at edge N is visible on out_valid/out_data after edge N (one cycle).
- Output FIFO:
  - First-word-fall-through; out_valid = !empty.
  - Pop occurs on out_valid && out_ready.
  - Simultaneous push and pop in the same cycle leaves the count unchanged and is legal when full.
  - out_data holds its value while out_valid && !out_ready.
- Protocol:
  - The upstream stage must hold in_valid/in_code/in_len/in_flush stable until accepted.
  - in_ready does not depend combinationally on in_valid.

Optional Feature:
- Macro: VLC_PACKER_BIT_COUNT_EN.
- Defined:
  - total_bits increments by L on every accept.
  - On flush it increments by the pad amount (32-fill when fill>0), so after flush_done it equals 32 × words emitted since reset.
  - Wraps modulo 2^32.
  - Cleared only by reset.
- Not defined: total_bits is tied to 0 and no counter logic exists.

Test Plan:
1. Word assembly: accept (0xABCD, 16), then (0x1234, 16), with out_ready=1 → out_valid for exactly one cycle, one cycle after the second accept, with out_data=0xABCD1234; fill=0.
2. Straddle plus flush:
   - Accept (0x3FFFFFFF, 30), then (0x6, 4) → one word 0xFFFFFFFD.
   - Then accept (0, 0, flush=1) → second word 0x80000000, flush_done pulses once, in_ready low for exactly one cycle.
3. Flush with empty accumulator: after test 1 completes, accept a flush → no word pushed; flush_done pulses the cycle after accept.
4. Backpressure:
   - Hold out_ready=0 and push FIFO_DEPTH words (4×(X,32)) → in_ready=0 after the fourth accept and out_data stays at the first word.
   - Raise out_ready for one cycle → in_ready=1 the following cycle; word order is preserved.
5. Length edge cases:
   - in_len=0 → no state change.
   - in_len=40 with code 0x12345678 → treated as 32 and emits 0x12345678.
   - With VLC_PACKER_BIT_COUNT_EN: total_bits=32 after these accepts.
6. Reset mid-stream:
   - Accept (0x5, 3) and fill the FIFO with 2 words, then assert reset_n=0 asynchronously → out_valid, flush_done and total_bits are 0 immediately.
   - After release, accept (0xFFFFFFFF, 32) → only 0xFFFFFFFF is emitted, with no stale bits.

Source files
------------

// File: rtl/vlc_bit_packer.sv
// vlc_bit_packer
// Packs variable-length codewords (0..32 bits, right-justified) MSB-first
// into a contiguous bitstream and emits 32-bit words through a small
// first-word-fall-through FIFO. A flush zero-pads residual bits to a word
// boundary and pulses flush_done.
//
// Optional build macro: VLC_PACKER_BIT_COUNT_EN enables the total_bits
// stream bit counter; without it total_bits is tied to zero.
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready     codeword handshake (accept = in_valid && in_ready)
//   in_code, in_len       codeword (low min(in_len,32) bits used)
//   in_flush              flush request, qualified by the accept
//   out_data/out_valid    packed word; stream's first bit is bit 31
//   out_ready             consumer pop (pop = out_valid && out_ready)
//   flush_done            one-cycle pulse when a flush completes
//   total_bits            stream bit count (0 unless the macro is defined)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; the sender holds its payload stable until that edge, and
// ready never depends combinationally on valid.
module vlc_bit_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_code,
  input  logic [5:0]  in_len,
  input  logic        in_flush,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        flush_done,
  output logic [31:0] total_bits
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  // r_state is the FSM state observable by checkers.
  state_t      r_state;
  logic [63:0] r_acc;    // pending bits, left-aligned; bits below fill are 0
  logic [4:0]  r_fill;   // pending bit count
  logic        r_flush_done;

  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic        w_full;
  logic        w_accept;
  logic [5:0]  w_len;
  logic [31:0] w_code_m;
  logic [63:0] w_code_ext;
  logic [63:0] w_acc_cat;
  logic [5:0]  w_new_fill;
  logic        w_push_run;
  logic        w_push_flush;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_push_data;

  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign in_ready  = reset_n && (r_state == S_RUN) && !w_full;
  assign w_accept  = in_valid && in_ready;

  // Lengths above 32 saturate; unused high code bits are masked off.
  assign w_len     = (in_len > 6'd32) ? 6'd32 : in_len;
  assign w_code_m  = (w_len == 6'd32) ? in_code
                                      : (in_code & ((32'd1 << w_len) - 32'd1));
  // Left-align the codeword at bit 63, then slide it behind the pending bits.
  assign w_code_ext = {w_code_m, 32'b0} << (6'd32 - w_len);
  assign w_acc_cat  = r_acc | (w_code_ext >> r_fill);
  assign w_new_fill = {1'b0, r_fill} + w_len;

  assign w_push_run   = w_accept && w_new_fill[5];
  assign w_push_flush = (r_state == S_FLUSH) && (r_fill != 5'd0) && !w_full;
  assign w_push       = w_push_run || w_push_flush;
  assign w_push_data  = w_push_run ? w_acc_cat[63:32] : r_acc[63:32];

  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rptr];
  assign w_pop      = out_valid && out_ready;
  assign flush_done = r_flush_done;

  // Packer FSM and accumulator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_RUN;
      r_acc        <= '0;
      r_fill       <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            // When a word is completed, low 5 bits of new fill = new-32.
            r_acc  <= w_new_fill[5] ? (w_acc_cat << 32) : w_acc_cat;
            r_fill <= w_new_fill[4:0];
            if (in_flush) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_fill == 5'd0) begin
            r_flush_done <= 1'b1;
            r_state      <= S_RUN;
          end else if (!w_full) begin
            r_acc        <= '0;
            r_fill       <= '0;
            r_flush_done <= 1'b1;
            r_state      <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Output FIFO (first-word-fall-through).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_push_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef VLC_PACKER_BIT_COUNT_EN
  logic [31:0] r_total_bits;

  // Counts codeword bits plus flush padding; wraps modulo 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_total_bits <= '0;
    end else if (w_accept) begin
      r_total_bits <= r_total_bits + 32'(w_len);
    end else if (w_push_flush) begin
      r_total_bits <= r_total_bits + 32'(6'd32 - {1'b0, r_fill});
    end
  end

  assign total_bits = r_total_bits;
`else
  assign total_bits = '0;
`endif

endmodule

// File: tb/tb_vlc_bit_packer.sv
// tb_vlc_bit_packer
// Directed and randomized bench for vlc_bit_packer. The reference model keeps
// the stream as a queue of bits: codewords are appended MSB-first, flushes pad
// with zeros to a multiple of 32, and every complete 32 bits become one
// expected word in exp_q. A negedge monitor compares each popped word.
module tb_vlc_bit_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_code = '0;
  logic [5:0]  in_len = '0;
  logic        in_flush = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        flush_done;
  logic [31:0] total_bits;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        bitq[$];
  logic [31:0] model_bits = '0;
  int          fd_exp = 0;
  int          fd_seen = 0;
  logic        rand_mode = 1'b0;
  logic        ready_force = 1'b1;

  vlc_bit_packer #(.FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_len     (in_len),
    .in_flush   (in_flush),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush_done (flush_done),
    .total_bits (total_bits)
  );

  // Clock / consumer ready generation
  always #5 clock = ~clock;

  always begin
    @(posedge clock);
    #2;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model
  task automatic model_accept(input logic [31:0] code, input logic [5:0] len, input logic flush);
    int l;
    logic [31:0] w;
    l = (len > 6'd32) ? 32 : int'(len);
    for (int i = l - 1; i >= 0; i--) bitq.push_back(code[i]);
    model_bits += 32'(l);
    if (flush) begin
      fd_exp++;
      if (bitq.size() % 32 != 0) begin
        int pad;
        pad = 32 - (bitq.size() % 32);
        repeat (pad) bitq.push_back(1'b0);
        model_bits += 32'(pad);
      end
    end
    while (bitq.size() >= 32) begin
      for (int i = 31; i >= 0; i--) w[i] = bitq.pop_front();
      exp_q.push_back(w);
    end
  endtask

  function automatic logic [31:0] exp_total();
`ifdef VLC_PACKER_BIT_COUNT_EN
    return model_bits;
`else
    return 32'd0;
`endif
  endfunction

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset_n) begin
      if (flush_done) fd_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL out_word_unexpected: observed=%h expected=none", out_data);
        end else begin
          chk("out_word", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks (all start and end at posedge+1)
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] code, input logic [5:0] len, input logic flush);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_code  = code;
    in_len   = len;
    in_flush = flush;
    while (!in_ready && waited < 300) begin
      cyc();
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed=in_ready_low expected=accept");
    end else begin
      model_accept(code, len, flush);
      cyc();
    end
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    rand_mode = 1'b0;
    ready_force = 1'b1;
    while (exp_q.size() > 0 && waited < 500) begin
      cyc();
      waited++;
    end
    chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    cyc();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic apply_reset();
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    bitq.delete();
    model_bits = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_total_bits", total_bits, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;
    int gap;

    // Reset state
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd0);
    chk("init_flush_done", 32'(flush_done), 32'd0);
    chk("init_total_bits", total_bits, 32'd0);
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: word assembly
    send(32'h0000ABCD, 6'd16, 1'b0);
    chk("t1_no_word_yet", 32'(out_valid), 32'd0);
    send(32'h00001234, 6'd16, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", out_data, 32'hABCD1234);
    cyc();
    chk("t1_valid_one_cycle", 32'(out_valid), 32'd0);

    // 2: straddle plus flush
    send(32'h3FFFFFFF, 6'd30, 1'b0);
    send(32'h00000006, 6'd4, 1'b0);
    chk("t2_data0", out_data, 32'hFFFFFFFD);
    send(32'h0, 6'd0, 1'b1);
    chk("t2_in_ready_low", 32'(in_ready), 32'd0);
    chk("t2_fd_not_yet", 32'(flush_done), 32'd0);
    cyc();
    chk("t2_data1", out_data, 32'h80000000);
    chk("t2_valid1", 32'(out_valid), 32'd1);
    chk("t2_flush_done", 32'(flush_done), 32'd1);
    chk("t2_in_ready_back", 32'(in_ready), 32'd1);
    cyc();
    chk("t2_fd_one_pulse", 32'(flush_done), 32'd0);
    chk("t2_total_bits", total_bits, exp_total());

    // 3: flush with empty accumulator
    send(32'h0, 6'd0, 1'b1);
    chk("t3_fd_not_yet", 32'(flush_done), 32'd0);
    chk("t3_in_ready_low", 32'(in_ready), 32'd0);
    cyc();
    chk("t3_flush_done", 32'(flush_done), 32'd1);
    chk("t3_no_word", 32'(out_valid), 32'd0);
    drain();

    // 4: backpressure
    ready_force = 1'b0;
    cyc();
    w0 = $urandom();
    w1 = $urandom();
    send(w0, 6'd32, 1'b0);
    send(w1, 6'd32, 1'b0);
    send($urandom(), 6'd32, 1'b0);
    send($urandom(), 6'd32, 1'b0);
    chk("t4_in_ready_full", 32'(in_ready), 32'd0);
    chk("t4_hold_first", out_data, w0);
    cyc();
    cyc();
    chk("t4_hold_first_later", out_data, w0);
    ready_force = 1'b1;
    cyc();
    ready_force = 1'b0;
    chk("t4_in_ready_after_pop", 32'(in_ready), 32'd1);
    chk("t4_second_word", out_data, w1);
    drain();
    chk("t4_fd_count", 32'(fd_seen), 32'(fd_exp));

    // 5: length edge cases (fresh stream)
    apply_reset();
    send($urandom(), 6'd0, 1'b0);
    cyc();
    chk("t5_len0_no_word", 32'(out_valid), 32'd0);
    chk("t5_len0_total", total_bits, exp_total());
    send(32'h12345678, 6'd40, 1'b0);
    chk("t5_len40_data", out_data, 32'h12345678);
    chk("t5_len40_valid", 32'(out_valid), 32'd1);
`ifdef VLC_PACKER_BIT_COUNT_EN
    chk("t5_total_bits", total_bits, 32'd32);
`else
    chk("t5_total_bits", total_bits, 32'd0);
`endif
    drain();

    // 6: reset mid-stream
    ready_force = 1'b0;
    cyc();
    send(32'h5, 6'd3, 1'b0);
    send($urandom(), 6'd32, 1'b0);
    send($urandom(), 6'd32, 1'b0);
    chk("t6_words_waiting", 32'(out_valid), 32'd1);
    apply_reset();
    ready_force = 1'b1;
    cyc();
    send(32'hFFFFFFFF, 6'd32, 1'b0);
    chk("t6_clean_word", out_data, 32'hFFFFFFFF);
    drain();

    // Randomized stream with random consumer backpressure
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      send($urandom(), 6'($urandom_range(0, 40)), ($urandom_range(0, 9) == 0));
      gap = $urandom_range(0, 2);
      repeat (gap) cyc();
    end
    send(32'h0, 6'd0, 1'b1);
    drain();
    chk("rand_fd_count", 32'(fd_seen), 32'(fd_exp));
    chk("rand_total_bits", total_bits, exp_total());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
